// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins by default; a saturating starvation counter hands priority to fetch.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic [1:0]        arb_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);
    localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] wait_cnt;
    logic [1:0] wait_cnt_nxt;
    logic       owner_fetch;
    logic [3:0] starve_cnt;
    logic       fetch_wins;
    logic       grant_ok;
    logic       read_gnt;
    logic       done;

    assign fetch_wins = fetch_req && (starve_cnt >= LIMIT);
    assign grant_ok   = (state == IDLE) && !reset;
    assign data_gnt   = grant_ok && data_req && !fetch_wins;
    assign fetch_gnt  = grant_ok && fetch_req && !data_gnt;
    assign read_gnt   = fetch_gnt || (data_gnt && !data_we);

    assign busy      = (state == WAIT);
    assign arb_state = state;

    // Only the granted request reaches the memory; otherwise drive zeros.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        unique case (1'b1)
            data_gnt: begin
                mem_address = data_addr;
                mem_wren    = data_we;
                mem_data    = data_we ? data_wdata : '0;
            end
            fetch_gnt: begin
                mem_address = fetch_addr;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        done         = 1'b0;
        unique case (state)
            IDLE: begin
                if (read_gnt) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = LAT_M1;
                end
            end
            WAIT: begin
                if (wait_cnt == 2'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 2'd0;
            owner_fetch <= 1'b0;
            fetch_valid <= 1'b0;
            data_valid  <= 1'b0;
            fetch_rdata <= '0;
            data_rdata  <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            fetch_valid <= done && owner_fetch;
            data_valid  <= done && !owner_fetch;
            if (read_gnt) begin
                owner_fetch <= fetch_gnt;
            end
            if (done && owner_fetch) begin
                fetch_rdata <= mem_q;
            end
            if (done && !owner_fetch) begin
                data_rdata <= mem_q;
            end
        end
    end

    // Counts consecutive denied fetch cycles, saturating at 15.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (fetch_req && !fetch_gnt) begin
            if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal checks plus a
// transaction-level model compared against the outputs every cycle.
module tb_mem_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LAT   = 1;
    localparam int LIMIT = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [DW-1:0] fetch_rdata;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_gnt;
    logic          data_valid;
    logic [DW-1:0] data_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic          busy;
    logic [1:0]    arb_state;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .fetch_valid(fetch_valid),
        .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_valid(data_valid), .data_rdata(data_rdata),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q),
        .busy(busy), .arb_state(arb_state)
    );

    always #5 clock = ~clock;

    // Main memory stand-in with one cycle of read latency.
    logic [DW-1:0] mem [0:65535];
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: remaining wait cycles, pending read value.
    logic [DW-1:0] ref_mem [0:65535];
    int            m_left = 0;
    bit            m_port_f = 1'b0;
    logic [DW-1:0] m_val = '0;
    bit            m_fv = 1'b0;
    bit            m_dv = 1'b0;
    logic [DW-1:0] m_fr = '0;
    logic [DW-1:0] m_dr = '0;
    int            m_starve = 0;

    always @(negedge clock) begin
        bit            idle, fw, e_dg, e_fg, e_wren, nfv, ndv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        idle   = (m_left == 0);
        fw     = fetch_req && (m_starve >= LIMIT);
        e_dg   = !reset && idle && data_req && !fw;
        e_fg   = !reset && idle && fetch_req && !e_dg;
        e_wren = e_dg && data_we;
        e_addr = e_dg ? data_addr : (e_fg ? fetch_addr : '0);
        e_data = e_wren ? data_wdata : '0;
        chk("m_fetch_gnt", 32'(fetch_gnt), 32'(e_fg));
        chk("m_data_gnt", 32'(data_gnt), 32'(e_dg));
        chk("m_mem_address", 32'(mem_address), 32'(e_addr));
        chk("m_mem_data", 32'(mem_data), 32'(e_data));
        chk("m_mem_wren", 32'(mem_wren), 32'(e_wren));
        chk("m_busy", 32'(busy), 32'(!idle));
        chk("m_arb_state", 32'(arb_state), idle ? 32'd0 : 32'd1);
        chk("m_fetch_valid", 32'(fetch_valid), 32'(m_fv));
        chk("m_data_valid", 32'(data_valid), 32'(m_dv));
        chk("m_fetch_rdata", 32'(fetch_rdata), 32'(m_fr));
        chk("m_data_rdata", 32'(data_rdata), 32'(m_dr));
        if (reset) begin
            m_left = 0; m_fv = 0; m_dv = 0;
            m_fr = '0; m_dr = '0; m_starve = 0;
        end else begin
            nfv = 0;
            ndv = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_port_f) begin nfv = 1; m_fr = m_val; end
                    else begin ndv = 1; m_dr = m_val; end
                end
            end
            if (e_fg) begin
                m_left = LAT; m_port_f = 1; m_val = ref_mem[fetch_addr];
            end else if (e_dg && !data_we) begin
                m_left = LAT; m_port_f = 0; m_val = ref_mem[data_addr];
            end
            if (e_wren) ref_mem[data_addr] = data_wdata;
            m_fv = nfv;
            m_dv = ndv;
            if (fetch_req && !e_fg) m_starve = (m_starve == 15) ? 15 : m_starve + 1;
            else m_starve = 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i) ^ 16'h3C3C;
            ref_mem[i] = 16'(i) ^ 16'h3C3C;
        end
        preload(16'h0010, 16'hABCD);
        preload(16'h0020, 16'h1234);
        preload(16'h0040, 16'h7777);

        // Reset for three cycles
        tick(); tick(); tick();
        #1;
        chk("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
        chk("rst_data_gnt", 32'(data_gnt), 32'd0);
        chk("rst_valids", 32'({fetch_valid, data_valid}), 32'd0);
        chk("rst_mem_wren", 32'(mem_wren), 32'd0);
        chk("rst_arb_state", 32'(arb_state), 32'd0);
        chk("rst_rdata", 32'({fetch_rdata, data_rdata}), 32'd0);
        tick();
        reset = 1'b0;

        // Single fetch read
        tick();
        fetch_req = 1'b1; fetch_addr = 16'h0010;
        #1;
        chk("t2_fetch_gnt", 32'(fetch_gnt), 32'd1);
        chk("t2_mem_address", 32'(mem_address), 32'h0010);
        tick();
        fetch_req = 1'b0;
        #1;
        chk("t2_busy", 32'(busy), 32'd1);
        tick(); #1;
        chk("t2_fetch_valid", 32'(fetch_valid), 32'd1);
        chk("t2_fetch_rdata", 32'(fetch_rdata), 32'hABCD);
        tick(); #1;
        chk("t2_valid_pulse", 32'(fetch_valid), 32'd0);

        // Simultaneous fetch and data read
        fetch_req = 1'b1; fetch_addr = 16'h0040;
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0020;
        #1;
        chk("t3_data_gnt", 32'(data_gnt), 32'd1);
        chk("t3_fetch_gnt0", 32'(fetch_gnt), 32'd0);
        tick();
        data_req = 1'b0;
        #1;
        chk("t3_wait_no_gnt", 32'(fetch_gnt), 32'd0);
        tick(); #1;
        chk("t3_data_valid", 32'(data_valid), 32'd1);
        chk("t3_data_rdata", 32'(data_rdata), 32'h1234);
        chk("t3_fetch_gnt", 32'(fetch_gnt), 32'd1);
        tick();
        fetch_req = 1'b0;
        tick(); #1;
        chk("t3_fetch_valid", 32'(fetch_valid), 32'd1);
        chk("t3_fetch_rdata", 32'(fetch_rdata), 32'h7777);

        // Write then read back
        tick();
        data_req = 1'b1; data_we = 1'b1;
        data_addr = 16'h0030; data_wdata = 16'h5A5A;
        #1;
        chk("t4_wr_gnt", 32'(data_gnt), 32'd1);
        chk("t4_wren", 32'(mem_wren), 32'd1);
        chk("t4_mem_data", 32'(mem_data), 32'h5A5A);
        tick();
        data_we = 1'b0;
        #1;
        chk("t4_rd_gnt", 32'(data_gnt), 32'd1);
        chk("t4_rd_wren", 32'(mem_wren), 32'd0);
        tick();
        data_req = 1'b0;
        tick(); #1;
        chk("t4_data_valid", 32'(data_valid), 32'd1);
        chk("t4_data_rdata", 32'(data_rdata), 32'h5A5A);

        // Write stream starving fetch
        tick();
        fetch_req = 1'b1; fetch_addr = 16'h0010;
        data_req = 1'b1; data_we = 1'b1;
        for (int k = 0; k < LIMIT; k++) begin
            data_addr = 16'h0100 + 16'(k); data_wdata = 16'hC000 + 16'(k);
            #1;
            chk("t5_wr_gnt", 32'(data_gnt), 32'd1);
            chk("t5_fetch_held", 32'(fetch_gnt), 32'd0);
            tick();
        end
        data_addr = 16'h0104; data_wdata = 16'hC004;
        #1;
        chk("t5_fetch_wins", 32'(fetch_gnt), 32'd1);
        chk("t5_data_denied", 32'(data_gnt), 32'd0);
        tick();
        fetch_req = 1'b0;
        #1;
        chk("t5_wait_denied", 32'(data_gnt), 32'd0);
        tick(); #1;
        chk("t5_wr_resume", 32'(data_gnt), 32'd1);
        chk("t5_fetch_rdata", 32'(fetch_rdata), 32'hABCD);
        tick();
        data_req = 1'b0;

        // Reset during WAIT
        tick();
        fetch_req = 1'b1; fetch_addr = 16'h0020;
        #1;
        chk("t6_gnt", 32'(fetch_gnt), 32'd1);
        tick();
        fetch_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t6_no_valid", 32'(fetch_valid), 32'd0);
        chk("t6_state", 32'(arb_state), 32'd0);
        tick();
        fetch_req = 1'b1; fetch_addr = 16'h0040;
        #1;
        chk("t6_regrant", 32'(fetch_gnt), 32'd1);
        tick();
        fetch_req = 1'b0;
        tick(); #1;
        chk("t6_valid", 32'(fetch_valid), 32'd1);
        chk("t6_rdata", 32'(fetch_rdata), 32'h7777);

        // Mixed traffic checked only by the model
        for (int i = 0; i < 400; i++) begin
            tick();
            reset      = ($urandom_range(0, 79) == 0);
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = 16'($urandom_range(0, 15));
            data_req   = 1'($urandom_range(0, 1));
            data_we    = 1'($urandom_range(0, 1));
            data_addr  = 16'($urandom_range(0, 15));
            data_wdata = 16'($urandom);
        end
        tick();
        reset = 1'b0; fetch_req = 1'b0; data_req = 1'b0;
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
